// File: rtl/dlfloat_mac_seq.sv
// Loads DLFloat16 operands A,B[,C] from the host, issues them to a MAC with valid/ready, serializes the result hi then lo byte.
// Result bytes start 1 cycle after res_valid; host is stalled (in_ready=0) from issue until OUT_LO; a missing result aborts after TIMEOUT cycles.
module dlfloat_mac_seq #(
  parameter int TIMEOUT = 15,
  parameter int W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         use_c,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [W-1:0] op_c,
  output logic         op_valid,
  input  logic         op_ready,
  input  logic         res_valid,
  input  logic [W-1:0] res_data,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  output logic         out_hi,
  output logic         err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    LD_A, LD_B, LD_C, ISSUE, WAIT_RES, OUT_HI, OUT_LO
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [W-1:0]   op_c_q, op_c_d;
  logic [W-1:0]   result_q, result_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [7:0]     byte_q, byte_d;
  logic           xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LD_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_c_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      byte_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_c_q   <= op_c_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      byte_q   <= byte_d;
    end
  end

  assign xfer = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_c_d   = op_c_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    byte_d   = byte_q;
    case (state_q)
      LD_A: begin
        if (xfer) begin
          op_a_d  = in_data;
          state_d = LD_B;
        end
      end
      LD_B: begin
        if (xfer) begin
          op_b_d = in_data;
          if (use_c) begin
            state_d = LD_C;
          end else begin
            op_c_d  = '0;
            state_d = ISSUE;
          end
        end
      end
      LD_C: begin
        if (xfer) begin
          op_c_d  = in_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_ready) begin
          cnt_d   = '0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (res_valid) begin
          result_d = res_data;
          byte_d   = res_data[15:8];
          state_d  = OUT_HI;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = cnt_q + CW'(1);
          err_d   = 1'b1;
          state_d = LD_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUT_HI: begin
        byte_d  = result_q[7:0];
        state_d = OUT_LO;
      end
      OUT_LO: begin
        state_d = LD_A;
      end
      default: begin
        state_d = LD_A;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    op_valid  = 1'b0;
    out_valid = 1'b0;
    out_hi    = 1'b0;
    case (state_q)
      LD_A, LD_B, LD_C: in_ready = 1'b1;
      ISSUE:            op_valid = 1'b1;
      OUT_HI: begin
        out_valid = 1'b1;
        out_hi    = 1'b1;
      end
      OUT_LO:           out_valid = 1'b1;
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_c     = op_c_q;
  assign out_byte = byte_q;
  assign err      = err_q;

endmodule
